// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus fabric rx/tx handshake for spi_slave.
// SPI_SLAVE_RX_OVERRUN_EN adds rx_ack and rx_overrun.
interface spi_slave_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              sclk;
    logic              cs;
    logic              din;
    logic              dout;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic              rx_ack;
    logic              rx_overrun;
`endif

    modport slave (
        input  sclk, cs, din, tx_data, tx_load,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        input  rx_ack,
        output rx_overrun,
`endif
        output dout, count, tx_ready, rx_data, rx_valid, tx_underrun
    );

    modport master (
        output sclk, cs, din, tx_data, tx_load,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        output rx_ack,
        input  rx_overrun,
`endif
        input  dout, count, tx_ready, rx_data, rx_valid, tx_underrun
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder, oversampled on clk, MSB first.
// Optional SPI_SLAVE_RX_OVERRUN_EN: rx_valid held until rx_ack, sticky rx_overrun.
module spi_slave #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_slave_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [2:0]        sclk_q;
    logic [2:0]        cs_q;
    logic [1:0]        din_q;
    logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic              do_start, do_abort, do_sample, do_reload, do_shift;
    logic [DATA_W-1:0] tx_shift, rx_shift, hold, rx_word, rx_data_q;
    logic [CNT_W-1:0]  count_q;
    logic              hold_full, word_done, rx_valid_q, underrun_q;
    logic              load_ok, last_bit;

    // cs sync resets low so a reset released with cs low cannot fake a fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            cs_q   <= '0;
            din_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sclk};
            cs_q   <= {cs_q[1:0], bus.cs};
            din_q  <= {din_q[0], bus.din};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_start  = 1'b0;
        do_abort  = 1'b0;
        do_sample = 1'b0;
        do_reload = 1'b0;
        do_shift  = 1'b0;
        unique case (state)
            IDLE: if (cs_fall) begin
                state_nx  = ACTIVE;
                do_start  = 1'b1;
                do_reload = 1'b1;
            end
            ACTIVE: if (cs_rise) begin
                state_nx = IDLE;
                do_abort = 1'b1;
            end else begin
                do_sample = sclk_rise;
                do_reload = sclk_fall & word_done;
                do_shift  = sclk_fall & ~word_done;
            end
        endcase
    end

    assign load_ok  = bus.tx_load & ~hold_full;
    assign last_bit = (count_q == CNT_W'(DATA_W - 1));
    assign rx_word  = {rx_shift[DATA_W-2:0], din_q[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= '0;
            hold_full  <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            count_q    <= '0;
            word_done  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            // a same-cycle reload still reads the old hold value
            if (load_ok) begin
                hold      <= bus.tx_data;
                hold_full <= 1'b1;
            end else if (do_reload) begin
                hold_full <= 1'b0;
            end
            if (do_reload) begin
                tx_shift <= hold_full ? hold : '0;
                if (!hold_full) underrun_q <= 1'b1;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
            if (do_start || do_abort) begin
                count_q   <= '0;
                word_done <= 1'b0;
            end else if (do_sample) begin
                rx_shift <= rx_word;
                if (last_bit) begin
                    count_q   <= '0;
                    word_done <= 1'b1;
                    rx_data_q <= rx_word;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
            end else if (do_reload) begin
                word_done <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (do_sample && last_bit) begin
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !bus.rx_ack) overrun_q <= 1'b1;
        end else if (bus.rx_ack) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign bus.rx_overrun = overrun_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_valid_q <= 1'b0;
        else        rx_valid_q <= do_sample & last_bit;
    end
`endif

    assign bus.dout        = (state == ACTIVE) & tx_shift[DATA_W-1];
    assign bus.count       = count_q;
    assign bus.tx_ready    = ~hold_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and random SPI mode-0 traffic against a word-level
// reference model, compared every clk, plus literal expectations.
module tb_spi_slave;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    spi_slave #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    assign bus.rx_ack = 1'b1;
`endif

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rand_load = 1'b0;

    int                rx_pulses = 0;
    int                rx_cyc    = 0;
    logic [DATA_W-1:0] rxq[$];
    logic              under_at_valid[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // word-level model: pin changes take effect three clk edges later
    bit                m_act, m_full, m_under, m_done, m_rxv;
    int                m_nrx, m_bit;
    logic [DATA_W-1:0] m_word, m_hold, m_rxd, m_acc;
    logic [3:1]        h_sclk, h_cs;
    logic [2:1]        h_din;

    task automatic model_reset();
        m_act = 0; m_full = 0; m_under = 0; m_done = 0; m_rxv = 0;
        m_nrx = 0; m_bit = 0;
        m_word = '0; m_hold = '0; m_rxd = '0; m_acc = '0;
        h_sclk = '0; h_cs = '0; h_din = '0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        logic              s_r, s_f, c_r, c_f, d, ld, reload, exp_dout;
        logic [DATA_W-1:0] old_hold;
        bit                old_full;
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            s_r = h_sclk[2] & ~h_sclk[3];
            s_f = ~h_sclk[2] & h_sclk[3];
            c_r = h_cs[2] & ~h_cs[3];
            c_f = ~h_cs[2] & h_cs[3];
            d   = h_din[2];
            ld  = bus.tx_load & ~m_full;
            old_hold = m_hold;
            old_full = m_full;
            reload = 0;
            m_rxv  = 0;
            if (!m_act) begin
                if (c_f) begin
                    m_act = 1; m_nrx = 0; m_done = 0; reload = 1;
                end
            end else if (c_r) begin
                m_act = 0; m_nrx = 0; m_done = 0;
            end else if (s_r) begin
                m_acc = (m_acc << 1) | DATA_W'(d);
                m_nrx++;
                if (m_nrx == DATA_W) begin
                    m_rxv = 1; m_rxd = m_acc; m_nrx = 0; m_done = 1;
                end
            end else if (s_f) begin
                if (m_done) begin
                    reload = 1; m_done = 0;
                end else begin
                    m_bit++;
                end
            end
            if (reload) begin
                m_word = old_full ? old_hold : '0;
                m_bit  = 0;
                if (!old_full) m_under = 1;
            end
            if (ld) begin
                m_hold = bus.tx_data; m_full = 1;
            end else if (reload) begin
                m_full = 0;
            end
            h_sclk = {h_sclk[2:1], bus.sclk};
            h_cs   = {h_cs[2:1], bus.cs};
            h_din  = {h_din[1], bus.din};
        end
        #1;
        exp_dout = (m_act && m_bit < DATA_W) ? m_word[DATA_W-1-m_bit] : 1'b0;
        check("dout", 32'(bus.dout), 32'(exp_dout));
        check("count", 32'(bus.count), 32'(m_nrx));
        check("tx_ready", 32'(bus.tx_ready), 32'(!m_full));
        check("rx_valid", 32'(bus.rx_valid), 32'(m_rxv));
        check("rx_data", 32'(bus.rx_data), 32'(m_rxd));
        check("tx_underrun", 32'(bus.tx_underrun), 32'(m_under));
        if (bus.rx_valid === 1'b1) begin
            rx_pulses++;
            rx_cyc = cyc;
            rxq.push_back(bus.rx_data);
            under_at_valid.push_back(bus.tx_underrun);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_load) begin
                bus.tx_load = ($urandom_range(0, 3) == 0);
                bus.tx_data = DATA_W'($urandom);
            end
        end
    endtask

    task automatic load(input logic [DATA_W-1:0] v);
        @(negedge clk);
        bus.tx_load = 1'b1;
        bus.tx_data = v;
        @(negedge clk);
        bus.tx_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        rxq.delete();
        under_at_valid.delete();
    endtask

    task automatic cs_low();
        bus.cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high(input int gap);
        tick(gap);
        bus.cs = 1'b1;
        tick(6);
    endtask

    task automatic xfer(input logic [DATA_W-1:0] mosi, input int nbits,
                        input int half, output logic [DATA_W-1:0] miso,
                        output int rise_cyc);
        miso = '0;
        rise_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            bus.din = mosi[DATA_W-1-i];
            tick(half);
            miso = {miso[DATA_W-2:0], bus.dout};
            bus.sclk = 1'b1;
            rise_cyc = cyc;
            tick(half);
            bus.sclk = 1'b0;
        end
    endtask

    initial begin
        logic [DATA_W-1:0] miso, miso2;
        int rc, p0, nw, half, nb;
        bus.sclk = 1'b0;
        bus.cs = 1'b1;
        bus.din = 1'b0;
        bus.tx_load = 1'b0;
        bus.tx_data = '0;

        // reset, then sclk toggling while deselected
        repeat (5) @(negedge clk);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            bus.sclk = 1'b1; tick(3);
            bus.sclk = 1'b0; tick(3);
        end
        check("idle_count", 32'(bus.count), 32'd0);

        // single transfer
        load(8'hA5);
        cs_low();
        p0 = rx_pulses;
        xfer(8'h3C, 8, 4, miso, rc);
        tick(2);
        check("single_miso", 32'(miso), 32'hA5);
        check("single_pulses", 32'(rx_pulses - p0), 32'd1);
        check("single_rx", 32'(rxq[rxq.size()-1]), 32'h3C);
        check("single_latency", 32'(rx_cyc - rc), 32'd3);
        cs_high(2);

        // back-to-back words
        do_reset();
        load(8'h81);
        cs_low();
        check("b2b_ready", 32'(bus.tx_ready), 32'd1);
        load(8'h7E);
        p0 = rx_pulses;
        xfer(8'hFF, 8, 4, miso, rc);
        xfer(8'h00, 8, 4, miso2, rc);
        tick(2);
        check("b2b_miso0", 32'(miso), 32'h81);
        check("b2b_miso1", 32'(miso2), 32'h7E);
        check("b2b_pulses", 32'(rx_pulses - p0), 32'd2);
        if (rxq.size() == 2) begin
            check("b2b_rx0", 32'(rxq[0]), 32'hFF);
            check("b2b_rx1", 32'(rxq[1]), 32'h00);
            check("b2b_underrun", 32'(under_at_valid[1]), 32'd0);
        end else begin
            check("b2b_rxq_size", 32'(rxq.size()), 32'd2);
        end
        cs_high(2);

        // underrun
        do_reset();
        cs_low();
        xfer(8'h6B, 8, 4, miso, rc);
        check("under_miso", 32'(miso), 32'h00);
        check("under_flag", 32'(bus.tx_underrun), 32'd1);
        cs_high(4);
        check("under_sticky", 32'(bus.tx_underrun), 32'd1);

        // abort after five rises, then a clean word
        do_reset();
        load(8'h33);
        cs_low();
        p0 = rx_pulses;
        xfer(8'hAA, 5, 4, miso, rc);
        cs_high(4);
        check("abort_pulses", 32'(rx_pulses - p0), 32'd0);
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_dout", 32'(bus.dout), 32'd0);
        load(8'h96);
        cs_low();
        xfer(8'h55, 8, 4, miso, rc);
        tick(2);
        check("abort_next_rx", 32'(rxq[rxq.size()-1]), 32'h55);
        check("abort_next_miso", 32'(miso), 32'h96);
        cs_high(2);

        // async reset between rises 3 and 4
        do_reset();
        load(8'h0F);
        cs_low();
        xfer(8'hF0, 3, 4, miso, rc);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("arst_dout", 32'(bus.dout), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("arst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("arst_rx_data", 32'(bus.rx_data), 32'd0);
        check("arst_underrun", 32'(bus.tx_underrun), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(4);
        check("arst_wait", 32'(bus.count), 32'd0);
        cs_high(0);
        load(8'h5A);
        cs_low();
        xfer(8'hC3, 8, 4, miso, rc);
        tick(2);
        check("arst_next_rx", 32'(rxq[rxq.size()-1]), 32'hC3);
        check("arst_next_miso", 32'(miso), 32'h5A);
        cs_high(2);

        // random frames, loads, rates and aborts
        rand_load = 1'b1;
        for (int f = 0; f < 40; f++) begin
            half = $urandom_range(2, 5);
            nw = $urandom_range(1, 3);
            cs_low();
            for (int w = 0; w < nw; w++) begin
                nb = ($urandom_range(0, 4) == 0) ?
                     $urandom_range(1, DATA_W - 1) : DATA_W;
                xfer(DATA_W'($urandom), nb, half, miso, rc);
                if (nb != DATA_W) break;
            end
            cs_high($urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) do_reset();
        end
        rand_load = 1'b0;
        bus.tx_load = 1'b0;
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0), the far end of the team's SPI master, which drives clk, sclk, din, dout, cs and count.
- Oversamples the master's sclk, cs and MOSI on the local system clock, shifts in one received word and simultaneously shifts out one transmit word, MSB first.
- Exposes a valid-pulse receive interface and a ready/load transmit holding register to the fabric.

Parameters:
- DATA_W, 8, bits per SPI word (2..16).
- CNT_W, 4, width of the count output; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  input  1  system clock; all logic on rising edge; frequency >= 4x sclk.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from master (asynchronous to clk).
- cs  input  1  chip select, active low.
- din  input  1  MOSI.
- dout  output  1  MISO.
- count  output  CNT_W  bits received in the current word (0..DATA_W-1).
- tx_data  input  DATA_W  next word to transmit.
- tx_load  input  1  write tx_data into holding register when tx_ready=1.
- tx_ready  output  1  holding register empty.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-clk pulse, rx_data updated.
- tx_underrun  output  1  sticky; a word boundary found the holding register empty.

Interface:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values: dout=0, count=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0; shift registers and holding register cleared.
- Synchronisation:
  - sclk, cs and din each pass through a 2-FF synchroniser.
  - Edges are detected against a third delayed stage of sclk and cs.
  - Every action below happens on the clk edge after detection. This gives a 3-clk latency from the raw pin change.
- States: IDLE (cs high), ACTIVE (cs low).
- cs falling edge (IDLE->ACTIVE):
  - tx shift reg <- holding register, tx_ready<=1, count<=0.
  - If the holding register was empty, load all zeros and set tx_underrun.
  - dout = tx_shift[DATA_W-1] from this cycle on.
- sclk rising edge while ACTIVE:
  - rx_shift <= {rx_shift[DATA_W-2:0], din_sync}.
  - If count == DATA_W-1: rx_data <= completed word, rx_valid=1 for exactly one clk, count<=0, word_done<=1.
  - Otherwise count<=count+1.
- sclk falling edge while ACTIVE:
  - If word_done: reload tx shift from the holding register (same underrun rule as cs falling edge, tx_ready<=1), word_done<=0.
  - Otherwise shift tx left by one, filling with 0.
  - The new MSB is on dout before the next sclk rise.
- Transmit handshake:
  - tx_load with tx_ready=1 captures tx_data; tx_ready<=0 next cycle.
  - tx_load with tx_ready=0 is ignored and the holding register is unchanged.
  - If tx_load and a reload occur in the same cycle, the reload takes the old holding value, the new data is captured, and tx_ready ends 0.
- cs rising edge mid-word (ACTIVE->IDLE):
  - Partial word discarded: no rx_valid, count<=0, word_done<=0, dout<=0.
  - The holding register is kept.
- sclk edges while in IDLE are ignored.
- tx_underrun is cleared only by reset.
- Asserting rst_n mid-transfer returns every output to its reset value immediately. The block waits for a fresh cs falling edge.

Optional Feature:
- Macro: SPI_SLAVE_RX_OVERRUN_EN.
- When defined:
  - Adds output rx_ack (input, 1) and rx_overrun (output, 1).
  - rx_valid becomes a level held until rx_ack=1.
  - A word completing while rx_valid is still high sets sticky rx_overrun and overwrites rx_data.
- When not defined: rx_valid is a single-clk pulse, neither port exists, and no overrun tracking is done.

Test Plan:
- Reset then idle: rst_n low 5 clks -> dout=0, count=0, tx_ready=1, rx_valid=0; toggling sclk with cs high leaves count at 0.
- Single transfer, DATA_W=8, sclk=clk/8:
  - Stimulus: tx_load 0xA5, cs low, master sends 0x3C.
  - Required: MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse 3 clks after the 8th sclk rise; count steps 0..7 then 0.
- Back-to-back words:
  - Stimulus: load 0x81, then reload 0x7E on tx_ready; 16 sclk cycles, master sends 0xFF,0x00.
  - Required: MISO 0x81 then 0x7E; rx_valid twice with 0xFF, 0x00; tx_underrun=0.
- Underrun: cs low with the holding register empty -> MISO 0x00, tx_underrun=1 and stays 1 after cs high.
- Abort: cs high after 5 sclk rises -> no rx_valid, count=0, dout=0; the next full word 0x55 is received correctly.
- Async reset mid-word: rst_n low between sclk rises 3 and 4 -> all outputs at reset values within the same cycle; a new transfer of 0xC3 is received correctly.
